// File: rtl/ps2_keyboard_tx_if.sv
// ps2_keyboard_tx_if: byte-push handshake into the PS/2 keyboard transmitter.
//   in_valid  producer -> tx   in_data carries a byte to queue
//   in_data   producer -> tx   8-bit scan-code byte
//   in_ready  tx -> producer   FIFO has room; depends on fill level only
// Handshake: a byte is transferred on every clk edge where in_valid && in_ready.
// in_valid does not wait for in_ready. A byte offered while in_ready=0 is dropped
// and never retried by the transmitter. in_ready never depends on in_valid.
interface ps2_keyboard_tx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx: device-side PS/2 transmitter (keyboard emulator).
// Bytes queue in a small FIFO and are sent as 11-bit frames
// (start 0, data LSB first, odd parity, stop 1) on a generated ps2_clk.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   in_if       byte push handshake (slave side), see ps2_keyboard_tx_if
//   ps2_clk     generated PS/2 clock, idle high, registered
//   ps2_data    PS/2 data, idle high, registered
//   busy        FIFO non-empty or a frame/gap in progress
//   fifo_count  bytes currently queued
//   state_dbg   current FSM state (0 idle, 1 send, 2 gap)
module ps2_keyboard_tx #(
  parameter int CLK_DIV    = 16,
  parameter int IDLE_GAP   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ps2_keyboard_tx_if.slave              in_if,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    state_dbg
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int DIV_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
  localparam int DW      = $clog2(DIV_MAX);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(IDLE_GAP - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  logic [1:0]    state;
  // Remaining frame bits after the start bit: {stop, parity, data[7:0]}.
  logic [9:0]    shift;
  logic [3:0]    bit_idx;
  logic          phase_high;
  logic [DW-1:0] div;

  assign head          = mem[rd_ptr];
  assign in_if.in_ready = (count != FIFO_FULL);
  assign push          = in_if.in_valid && in_if.in_ready;
  assign pop           = (state == S_IDLE) && (count != '0);

  assign busy       = (count != '0) || (state != S_IDLE);
  assign fifo_count = count;
  assign state_dbg  = state;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_if.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      shift      <= '1;
      bit_idx    <= '0;
      phase_high <= 1'b1;
      div        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            // Start bit goes out immediately; ps2_clk stays high for a full
            // half-period so data is stable well before the first fall.
            shift      <= {1'b1, ~^head, head};
            ps2_data   <= 1'b0;
            ps2_clk    <= 1'b1;
            bit_idx    <= '0;
            phase_high <= 1'b1;
            div        <= '0;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (phase_high) begin
              ps2_clk    <= 1'b0;
              phase_high <= 1'b0;
            end else begin
              // Data only moves together with the rising clock edge.
              ps2_clk    <= 1'b1;
              phase_high <= 1'b1;
              if (bit_idx == 4'd10) begin
                ps2_data <= 1'b1;
                state    <= S_GAP;
              end else begin
                bit_idx  <= bit_idx + 4'd1;
                ps2_data <= shift[0];
                shift    <= {1'b1, shift[9:1]};
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_GAP: begin
          if (div == GAP_LAST) begin
            div   <= '0;
            state <= S_IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx: closed-loop bench for ps2_keyboard_tx.
// A line monitor samples ps2_data on every ps2_clk fall, rebuilds 11-bit
// frames and compares them against frames queued when a push was accepted.
// It also checks half-period spacing, data stability while ps2_clk is low,
// and the idle gap between frames.
module tb_ps2_keyboard_tx;
  localparam int CLK_DIV    = 4;
  localparam int IDLE_GAP   = 8;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_count;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ps2_keyboard_tx_if in_if ();

  ps2_keyboard_tx #(
    .CLK_DIV    (CLK_DIV),
    .IDLE_GAP   (IDLE_GAP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .fifo_count (fifo_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // ---------------- line monitor ----------------
  logic        prev_clk    = 1'b1;
  logic        prev_data   = 1'b1;
  int          since_edge  = 0;
  int          mon_bits    = 0;
  logic [10:0] mon_frame   = '0;
  bit          have_rise   = 1'b0;
  bit          b2b         = 1'b0;
  bit          low_change  = 1'b0;
  int          edge_total  = 0;
  int          frames_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_clk   = ps2_clk;
      prev_data  = ps2_data;
      mon_bits   = 0;
      have_rise  = 1'b0;
      since_edge = 0;
      low_change = 1'b0;
    end else begin
      since_edge++;
      if (prev_clk && !ps2_clk) begin
        edge_total++;
        check("fall_spacing", since_edge, CLK_DIV);
        since_edge = 0;
        if (mon_bits < 11) begin
          mon_frame[mon_bits] = ps2_data;
          mon_bits++;
        end
        if (mon_bits == 11) begin
          frames_seen++;
          if (exp_q.size() == 0) check("frame_unexpected", exp_q.size(), 1);
          else check("frame", mon_frame, exp_q.pop_front());
        end
      end else if (!prev_clk && ps2_clk) begin
        edge_total++;
        check("rise_spacing", since_edge, CLK_DIV);
        check("low_stable", low_change, 0);
        low_change = 1'b0;
        since_edge = 0;
        if (mon_bits == 11) begin
          mon_bits  = 0;
          have_rise = 1'b1;
          b2b       = (fifo_count != 0);
        end
      end else if (ps2_clk && prev_data && !ps2_data && mon_bits == 0) begin
        if (have_rise) begin
          if (b2b) check("b2b_gap", since_edge, IDLE_GAP + 1);
          else     check("min_gap", since_edge >= IDLE_GAP + 1, 1);
        end
        since_edge = 0;
      end
      if (!prev_clk && !ps2_clk && (prev_data != ps2_data)) low_change = 1'b1;
      prev_clk  = ps2_clk;
      prev_data = ps2_data;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic push_byte(input logic [7:0] b, input logic [10:0] frame, output bit accepted);
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    accepted       = in_if.in_ready;
    if (accepted) exp_q.push_back(frame);
    @(negedge clk);
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // bit 0 = start bit, bit 10 = stop bit
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0b expected finish", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base;
    int acc_cnt;
    int edges_before;

    vecs[0] = '{8'h1C, 11'h438};
    vecs[1] = '{8'hF0, 11'h7E0};
    vecs[2] = '{8'h00, 11'h600};
    vecs[3] = '{8'hFF, 11'h7FE};
    vecs[4] = '{8'hA5, 11'h74A};
    vecs[5] = '{8'h01, 11'h402};

    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_if.in_ready, 1);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: push-to-start latency and full frame
    base = frames_seen;
    push_byte(8'h1C, 11'h438, acc);
    check("t1_accept", acc, 1);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_data_still_idle", ps2_data, 1);
    @(negedge clk);
    check("t1_start_bit", ps2_data, 0);
    check("t1_clk_high_at_start", ps2_clk, 1);
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_busy", busy, 1);
    wait_idle(400);
    check("t1_frames", frames_seen, base + 1);
    check("t1_idle_clk", ps2_clk, 1);
    check("t1_idle_data", ps2_data, 1);

    // Table of single-byte frames, including parity extremes 0x00 / 0xFF
    for (int i = 0; i < 6; i++) begin
      base = frames_seen;
      push_byte(vecs[i].data, vecs[i].frame, acc);
      check("tbl_accept", acc, 1);
      wait_idle(400);
      check("tbl_frames", frames_seen, base + 1);
    end

    // Back-to-back bytes: second push lands on the pop edge
    base = frames_seen;
    push_byte(8'hF0, frame_of(8'hF0), acc);
    push_byte(8'h1C, frame_of(8'h1C), acc);
    check("t2_count_push_on_pop", fifo_count, 1);
    wait_idle(800);
    check("t2_frames", frames_seen, base + 2);

    // Overflow with in_valid held: the byte offered while full is dropped
    base    = frames_seen;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      push_byte(b, frame_of(b), acc);
      if (acc) acc_cnt++;
      if (fifo_count == 3'(FIFO_DEPTH)) check("t4_ready_low_when_full", in_if.in_ready, 0);
    end
    check("t4_accepted", acc_cnt, 5);
    wait_idle(2000);
    check("t4_frames", frames_seen, base + 5);

    // Push on the same edge as an idle pop, count 1 before the edge
    base = frames_seen;
    push_byte(8'h3C, frame_of(8'h3C), acc);
    push_byte(8'hC3, frame_of(8'hC3), acc);
    check("t6_count_unchanged", fifo_count, 1);
    wait_idle(800);
    check("t6_frames", frames_seen, base + 2);

    // Reset mid-frame with two bytes still queued
    push_byte(8'h55, frame_of(8'h55), acc);
    push_byte(8'h66, frame_of(8'h66), acc);
    push_byte(8'h77, frame_of(8'h77), acc);
    begin
      int n = 0;
      while (mon_bits != 6 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_reached_bit5", mon_bits, 6);
    check("t5_queued", fifo_count, 2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    edges_before = edge_total;
    check("t5_clk_high", ps2_clk, 1);
    check("t5_data_high", ps2_data, 1);
    check("t5_flushed", fifo_count, 0);
    check("t5_busy", busy, 0);
    check("t5_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_edges", edge_total, edges_before);
    check("t5_lines_idle", {ps2_clk, ps2_data}, 2'b11);

    // Recovery after reset
    base = frames_seen;
    push_byte(8'h5A, frame_of(8'h5A), acc);
    check("t5_recover_accept", acc, 1);
    wait_idle(400);
    check("t5_recover_frames", frames_seen, base + 1);

    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
